// File: rtl/adder_pkg.sv
// Shared definitions for the extended adder and the blocks that consume its results.
package adder_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_INC = 2'b10,
    MODE_DEC = 2'b11
  } mode_e;

  // One buffered adder result together with its derived status flags.
  typedef struct packed {
    logic [1:0]        mode;
    logic              cout;
    logic              zero;
    logic              neg;
    logic              ovf;
    logic [WORD_W-1:0] result;
  } entry_t;

endpackage

// File: rtl/adder_flag_gen.sv
// Status flag derivation for an adder result. The overflow rule depends only on the
// operand and result sign bits, so any consumer of the adder can reuse this block.
module adder_flag_gen
  import adder_pkg::*;
(
  input  logic [1:0]        mode,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic [WORD_W-1:0] result,
  output logic              zero,
  output logic              neg,
  output logic              ovf
);

  logic sa, sb, sr;

  assign sa   = a[WORD_W-1];
  assign sb   = b[WORD_W-1];
  assign sr   = result[WORD_W-1];
  assign zero = (result == '0);
  assign neg  = sr;

  // Signed overflow per mode; operand B does not take part for increment/decrement.
  always_comb begin
    ovf = 1'b0;
    case (mode)
      MODE_ADD: ovf = (sa == sb) && (sr != sa);
      MODE_SUB: ovf = (sa != sb) && (sr != sa);
      MODE_INC: ovf = !sa && sr;
      default:  ovf = sa && !sr;
    endcase
  end

endmodule

// File: rtl/adder_result_stage.sv
// Registered result stage behind the extended adder: captures each result with its
// flags into a small FIFO and keeps saturating operation and overflow counters.
// All outputs, including in_ready, come from registered state only.
module adder_result_stage
  import adder_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_mode,
  input  logic [WORD_W-1:0] in_a,
  input  logic [WORD_W-1:0] in_b,
  input  logic [WORD_W-1:0] in_result,
  input  logic              in_cout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_result,
  output logic              out_cout,
  output logic [1:0]        out_mode,
  output logic              out_zero,
  output logic              out_neg,
  output logic              out_ovf,
  output logic [CNT_W-1:0]  op_count,
  output logic [CNT_W-1:0]  ovf_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic   full, empty, push, pop;
  logic   f_zero, f_neg, f_ovf;
  entry_t new_entry;
  entry_t head;

  adder_flag_gen u_flag_gen (
    .mode   (in_mode),
    .a      (in_a),
    .b      (in_b),
    .result (in_result),
    .zero   (f_zero),
    .neg    (f_neg),
    .ovf    (f_ovf)
  );

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  // in_ready ignores a same-cycle pop so it never depends on out_ready.
  assign push  = in_valid && !full;
  assign pop   = out_ready && !empty;

  assign new_entry = '{mode:   in_mode,
                       cout:   in_cout,
                       zero:   f_zero,
                       neg:    f_neg,
                       ovf:    f_ovf,
                       result: in_result};

  // Entry storage; only the slot under the write pointer changes on a push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (!clear && push) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  // Pointers and occupancy; clear wins over any push or pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Saturating statistics of accepted operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count  <= '0;
      ovf_count <= '0;
    end else if (clear) begin
      op_count  <= '0;
      ovf_count <= '0;
    end else if (push) begin
      if (op_count != '1)           op_count  <= op_count + 1'b1;
      if (f_ovf && ovf_count != '1) ovf_count <= ovf_count + 1'b1;
    end
  end

  assign head       = mem[rd_ptr];
  assign in_ready   = !full;
  assign out_valid  = !empty;
  assign out_result = head.result;
  assign out_cout   = head.cout;
  assign out_mode   = head.mode;
  assign out_zero   = head.zero;
  assign out_neg    = head.neg;
  assign out_ovf    = head.ovf;

endmodule

// File: tb/tb_adder_result_stage.sv
// Bench for adder_result_stage: a queue-based reference model checked every cycle,
// directed scenarios with literal expectations, randomized traffic, and a small
// second instance for the parameter and saturation corners.
module tb_adder_result_stage;
  import adder_pkg::*;

  localparam int DEPTH = 2;
  localparam int CNT_W = 16;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_mode = 2'b00;
  logic [31:0] in_a = '0, in_b = '0, in_result = '0;
  logic        in_cout = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_cout, out_zero, out_neg, out_ovf;
  logic [1:0]  out_mode;
  logic [CNT_W-1:0] op_count, ovf_count;

  // small instance: DEPTH 4, 4-bit counters
  logic        s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b0;
  logic [31:0] s_out_result;
  logic        s_out_cout, s_out_zero, s_out_neg, s_out_ovf;
  logic [1:0]  s_out_mode;
  logic [3:0]  s_op_count, s_ovf_count;

  always #5 clk = ~clk;

  adder_result_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_a(in_a), .in_b(in_b), .in_result(in_result), .in_cout(in_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_cout(out_cout), .out_mode(out_mode), .out_zero(out_zero),
    .out_neg(out_neg), .out_ovf(out_ovf),
    .op_count(op_count), .ovf_count(ovf_count)
  );

  adder_result_stage #(.DEPTH(4), .CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .clear(1'b0),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_mode(2'b00),
    .in_a(32'h7FFF_FFFF), .in_b(32'h0000_0001), .in_result(32'h8000_0000), .in_cout(1'b0),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_result(s_out_result),
    .out_cout(s_out_cout), .out_mode(s_out_mode), .out_zero(s_out_zero),
    .out_neg(s_out_neg), .out_ovf(s_out_ovf),
    .op_count(s_op_count), .ovf_count(s_ovf_count)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] result;
    logic        cout;
    logic [1:0]  mode;
    bit          ovf;
  } exp_t;

  exp_t mq[$];
  logic [CNT_W-1:0] m_op = '0, m_ovf = '0;
  logic [31:0] popped[$];

  // Correct adder output for a mode.
  function automatic logic [31:0] adder_out(input logic [1:0] mode, input logic [31:0] a,
                                            input logic [31:0] b);
    case (mode)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a + 32'd1;
      default: return a - 32'd1;
    endcase
  endfunction

  // Overflow = exact signed outcome does not fit in 32 bits.
  function automatic bit exp_ovf(input logic [1:0] mode, input logic [31:0] a,
                                 input logic [31:0] b);
    longint sa, sb, x;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (mode)
      2'b00:   x = sa + sb;
      2'b01:   x = sa - sb;
      2'b10:   x = sa + 1;
      default: x = sa - 1;
    endcase
    return (x > SMAX) || (x < SMIN);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_op  <= '0;
      m_ovf <= '0;
    end else if (clear) begin
      mq.delete();
      m_op  <= '0;
      m_ovf <= '0;
    end else begin
      automatic bit   do_push = in_valid && (mq.size() < DEPTH);
      automatic bit   do_pop  = out_ready && (mq.size() > 0);
      automatic exp_t e;
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        e.result = in_result;
        e.cout   = in_cout;
        e.mode   = in_mode;
        e.ovf    = exp_ovf(in_mode, in_a, in_b);
        mq.push_back(e);
        if (m_op != '1) m_op <= m_op + 1'b1;
        if (e.ovf && m_ovf != '1) m_ovf <= m_ovf + 1'b1;
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("m_out_valid", out_valid, mq.size() != 0);
      check("m_in_ready", in_ready, mq.size() < DEPTH);
      if (mq.size() != 0) begin
        check("m_out_result", out_result, mq[0].result);
        check("m_out_cout", out_cout, mq[0].cout);
        check("m_out_mode", out_mode, mq[0].mode);
        check("m_out_zero", out_zero, mq[0].result == 32'd0);
        check("m_out_neg", out_neg, mq[0].result[31]);
        check("m_out_ovf", out_ovf, mq[0].ovf);
      end
      check("m_op_count", op_count, m_op);
      check("m_ovf_count", ovf_count, m_ovf);
    end
  end

  // Record every value the consumer actually takes.
  always @(negedge clk) begin
    if (rst_n && !clear && out_valid && out_ready) popped.push_back(out_result);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] mode, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input logic cout);
    bit r;
    bit done = 1'b0;
    in_valid  = 1'b1;
    in_mode   = mode;
    in_a      = a;
    in_b      = b;
    in_result = res;
    in_cout   = cout;
    for (int t = 0; t < 50 && !done; t++) begin
      r = in_ready;
      tick();
      if (r) done = 1'b1;
    end
    if (!done) check("send_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    logic [1:0]  m;
    int          t0;

    // reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_result", out_result, 0);
    check("rst_out_flags", {out_cout, out_mode, out_zero, out_neg, out_ovf}, 0);
    check("rst_counters", {op_count, ovf_count}, 0);
    tick();
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick();

    // basic add, no bypass in the push cycle
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_mode = MODE_ADD; in_a = 32'h10; in_b = 32'h20; in_result = 32'h30; in_cout = 1'b0;
    #1;
    check("no_bypass", out_valid, 0);
    send(MODE_ADD, 32'h10, 32'h20, 32'h30, 1'b0);
    check("add_valid", out_valid, 1);
    check("add_result", out_result, 32'h30);
    check("add_flags", {out_zero, out_neg, out_ovf}, 3'b000);
    check("add_op_count", op_count, 1);

    send(MODE_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0);
    check("add_ovf_flags", {out_neg, out_ovf}, 2'b11);
    check("add_ovf_count", ovf_count, 1);

    send(MODE_DEC, 32'h8000_0000, 32'h1234_5678, 32'h7FFF_FFFF, 1'b1);
    check("dec_ovf", out_ovf, 1);
    check("dec_cout", out_cout, 1);
    check("dec_ovf_count", ovf_count, 2);

    send(MODE_SUB, 32'h20, 32'h20, 32'h0, 1'b1);
    check("sub_zero_flags", {out_zero, out_ovf}, 2'b10);
    check("sub_op_count", op_count, 4);
    in_valid = 1'b0;
    tick();

    // backpressure: three pushes against a stalled consumer
    clear = 1'b1; tick(); clear = 1'b0;
    popped.delete();
    out_ready = 1'b0;
    send(MODE_ADD, 32'h1, 32'h10, 32'h11, 1'b0);
    send(MODE_ADD, 32'h2, 32'h10, 32'h12, 1'b0);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_head_held", out_result, 32'h11);
    fork
      send(MODE_ADD, 32'h3, 32'h10, 32'h13, 1'b0);
      begin
        repeat (3) tick();
        check("bp_stall_head", out_result, 32'h11);
        out_ready = 1'b1;
      end
    join
    in_valid = 1'b0;
    repeat (4) tick();
    check("bp_pop_count", popped.size(), 3);
    if (popped.size() == 3) begin
      check("bp_order0", popped[0], 32'h11);
      check("bp_order1", popped[1], 32'h12);
      check("bp_order2", popped[2], 32'h13);
    end
    check("bp_in_ready_back", in_ready, 1);

    // streaming: one result per cycle
    clear = 1'b1; tick(); clear = 1'b0;
    popped.delete();
    out_ready = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 20; i++) send(MODE_INC, i, 32'h0, i + 1, 1'b0);
    check("stream_cycles", cyc - t0, 20);
    in_valid = 1'b0;
    repeat (2) tick();
    check("stream_op_count", op_count, 20);
    check("stream_pop_count", popped.size(), 20);
    for (int i = 0; i < popped.size() && i < 20; i++) check("stream_order", popped[i], i + 1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      a = pick_operand();
      b = ($urandom_range(0, 3) == 0) ? a : pick_operand();
      m = 2'($urandom_range(0, 3));
      in_valid  = ($urandom_range(0, 3) != 0);
      in_mode   = m;
      in_a      = a;
      in_b      = b;
      in_result = adder_out(m, a, b);
      in_cout   = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
      clear     = ($urandom_range(0, 49) == 0);
      tick();
    end
    clear = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();

    // clear with a concurrent push on a full FIFO
    clear = 1'b1; tick(); clear = 1'b0;
    popped.delete();
    out_ready = 1'b0;
    send(MODE_ADD, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    send(MODE_ADD, 32'h5, 32'h6, 32'hB, 1'b0);
    check("pre_clear_counts", {op_count, ovf_count}, {16'd2, 16'd1});
    clear = 1'b1;
    in_valid = 1'b1; in_mode = MODE_ADD; in_a = 32'h1; in_b = 32'h1; in_result = 32'hDEAD;
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    check("clear_valid", out_valid, 0);
    check("clear_counters", {op_count, ovf_count}, 0);
    out_ready = 1'b1;
    repeat (3) tick();
    check("clear_drop_push", popped.size(), 0);
    check("clear_still_empty", out_valid, 0);

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    send(MODE_SUB, 32'h9, 32'h3, 32'h6, 1'b1);
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_counters", {op_count, ovf_count}, 0);
    check("arst_data", out_result, 0);
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // deeper FIFO and counter saturation on the small instance
    s_out_ready = 1'b0;
    s_in_valid = 1'b1;
    repeat (6) tick();
    check("small_full_count", s_op_count, 4);
    check("small_in_ready", s_in_ready, 0);
    check("small_head_ovf", {s_out_valid, s_out_ovf, s_out_neg}, 3'b111);
    s_out_ready = 1'b1;
    repeat (30) tick();
    check("small_op_sat", s_op_count, 4'hF);
    check("small_ovf_sat", s_ovf_count, 4'hF);
    s_in_valid = 1'b0;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_result_stage.md
Name: adder_result_stage

Overview:
- Registered output stage directly downstream of the 32-bit extended adder (modes 00 add, 01 sub, 10 increment A, 11 decrement A).
- Captures Result/Cout plus operand context under valid/ready, derives status flags, buffers results in a small FIFO and keeps saturating operation/overflow counters.
- Decouples the combinational adder from the consumer (writeback or display logic).

Parameters:
- DEPTH, 2, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous flush of FIFO and counters
- in_valid  in  1  adder output valid
- in_ready  out  1  stage can accept; equals !full
- in_mode  in  2  adder mode for this result
- in_a  in  32  adder operand A
- in_b  in  32  adder operand B; ignored for modes 10/11
- in_result  in  32  adder Result
- in_cout  in  1  adder Cout
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer accepts head
- out_result  out  32  buffered result
- out_cout  out  1  buffered carry
- out_mode  out  2  buffered mode
- out_zero  out  1  result == 0
- out_neg  out  1  result[31]
- out_ovf  out  1  signed overflow
- op_count  out  CNT_W  accepted operations, saturating
- ovf_count  out  CNT_W  accepted operations with ovf = 1, saturating

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, pointers 0, out_valid 0, in_ready 1, all out_* data 0, both counters 0. Reset asserted mid-transfer discards all contents; there is no partial state.
- Push happens when in_valid && in_ready. Pop happens when out_valid && out_ready.
- Flags are computed combinationally from the input on push and stored with the entry. Let sa = in_a[31], sb = in_b[31], sr = in_result[31].
  - 00 add: ovf = (sa == sb) && (sr != sa)
  - 01 sub: ovf = (sa != sb) && (sr != sa)
  - 10 inc: ovf = !sa && sr
  - 11 dec: ovf = sa && !sr
  - zero = (in_result == 0); neg = sr.
- Latency: a push into an empty FIFO raises out_valid on the next rising edge. The stage has no combinational path from input to output.
- out_* data always reflect the head entry and hold stable while out_valid && !out_ready.
- Full FIFO: in_ready = 0, even when a pop occurs in the same cycle. This keeps in_ready a function of registered state only.
- Empty FIFO with simultaneous push: no bypass. out_valid stays 0 in the push cycle.
- Push and pop in the same cycle (not full, not empty): occupancy is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. Occupancy counter is clog2(DEPTH)+1 bits.
- Counters: op_count increments on every push; ovf_count increments on a push with ovf = 1. Both stick at all-ones (no wrap).
- clear: on the next edge, empties the FIFO and zeroes both counters. clear overrides any push or pop in that cycle, so a push made during clear is dropped.
- Cout is passed through unmodified. It is not used for flag derivation.

Decomposition:
- Shared package adder_pkg holds:
  - mode constants MODE_ADD = 2'b00, MODE_SUB = 2'b01, MODE_INC = 2'b10, MODE_DEC = 2'b11
  - WORD_W = 32
  - a packed entry typedef {mode, cout, zero, neg, ovf, result}
- One sub-module, adder_flag_gen: the combinational flag derivation above, reusable by other consumers of the adder.
- FIFO storage and pointers stay inline in adder_result_stage.

Test Plan:
- Mode 00, A = 0x10, B = 0x20, Result = 0x30, out_ready = 1 → one cycle later: out_valid = 1, out_result = 0x30, zero = 0, neg = 0, ovf = 0; op_count = 1.
- Mode 00, A = 0x7FFFFFFF, B = 1, Result = 0x80000000 → ovf = 1, neg = 1, ovf_count = 1. Then mode 11, A = 0x80000000, Result = 0x7FFFFFFF → ovf = 1, ovf_count = 2.
- Mode 01, A = 0x20, B = 0x20, Result = 0 → zero = 1, ovf = 0.
- out_ready held at 0 while pushing 3 results (0x11, 0x12, 0x13):
  - in_ready drops after the 2nd push; the 3rd is held by the source.
  - Raise out_ready: outputs appear in order 0x11, 0x12, 0x13 with no loss or duplication, and in_ready returns to 1.
- Streaming with in_valid = out_ready = 1 for 20 cycles, incrementing results → one result per cycle, order preserved, op_count = 20. Force op_count to 0xFFFE, push 3 more → op_count holds at 0xFFFF.
- FIFO holding 2 entries with nonzero counters:
  - Pulse clear together with in_valid → next cycle out_valid = 0, counters = 0, and the pushed value never appears.
  - Assert rst_n low asynchronously mid-stream → out_valid = 0 immediately, before the next clock edge.
